// File: rtl/sensor_timing_pkg.sv
// Shared sensor-timing constants, also used by the readout and ADC capture blocks.
package sensor_timing_pkg;

    localparam int DIV_MIN         = 2;
    localparam int CNT_W_DEF       = 8;
    localparam int DEFAULT_DIV_DEF = 20;
    localparam int PIXELS_DEF      = 128;
    localparam int PIX_W_DEF       = 8;

endpackage

// File: rtl/sensor_div_core.sv
// Programmable divider: period counter, ratio register with boundary-deferred reload,
// registered sensor clock and terminal-count tick.
module sensor_div_core
    import sensor_timing_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_3M,
    input  logic             reset,
    input  logic             run_d,
    input  logic             run_q,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             sensor_clk,
    output logic             sensor_tick,
    output logic             div_err
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_LO  = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cntr, cntr_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             load_ok, load_bad, boundary, sensor_clk_d;

    assign load_ok     = div_load && (div_in >= DIV_LO);
    assign load_bad    = div_load && (div_in < DIV_LO);
    assign sensor_tick = run_q && (cntr == div_q - ONE);
    assign boundary    = sensor_tick || !run_q;

    // A load in the tick cycle is folded into pending first, so it governs the next period.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        div_d      = div_q;
        if (load_ok) begin
            pend_d     = div_in;
            pend_vld_d = 1'b1;
        end
        if (boundary && pend_vld_d) begin
            div_d      = pend_d;
            pend_vld_d = 1'b0;
        end
        cntr_d = '0;
        if (run_d && run_q && !sensor_tick)
            cntr_d = cntr + ONE;
        sensor_clk_d = run_d && (cntr_d < (div_d >> 1));
    end

    // Register stage: counter, ratio, pending slot and the glitch-free clock flop.
    always_ff @(posedge clk_3M or posedge reset) begin
        if (reset) begin
            cntr       <= '0;
            div_q      <= DIV_RST;
            pend_q     <= DIV_RST;
            pend_vld_q <= 1'b0;
            sensor_clk <= 1'b0;
            div_err    <= 1'b0;
        end else begin
            cntr       <= cntr_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sensor_clk <= sensor_clk_d;
            div_err    <= load_bad;
        end
    end

endmodule

// File: rtl/sensor_timing_gen.sv
// Sensor timing generator: run control, pixel sequencing and frame strobes around
// the programmable clock divider.
module sensor_timing_gen
    import sensor_timing_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter int PIXELS      = PIXELS_DEF,
    parameter int PIX_W       = PIX_W_DEF
) (
    input  logic             clk_3M,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             sensor_clk,
    output logic             sensor_tick,
    output logic             start_pulse,
    output logic [PIX_W-1:0] pixel_idx,
    output logic             frame_done,
    output logic             div_err
);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
    localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);

    logic             run_q;
    logic [PIX_W-1:0] pix_d;

    function automatic logic [PIX_W-1:0] pix_wrap(input logic [PIX_W-1:0] idx);
        return (idx == PIX_LAST) ? '0 : idx + PIX_ONE;
    endfunction

    sensor_div_core #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_div (
        .clk_3M      (clk_3M),
        .reset       (reset),
        .run_d       (enable),
        .run_q       (run_q),
        .div_in      (div_in),
        .div_load    (div_load),
        .sensor_clk  (sensor_clk),
        .sensor_tick (sensor_tick),
        .div_err     (div_err)
    );

    always_comb begin
        pix_d = '0;
        if (enable && run_q)
            pix_d = sensor_tick ? pix_wrap(pixel_idx) : pixel_idx;
    end

    assign frame_done = sensor_tick && (pixel_idx == PIX_LAST);

    // Register stage: run flag, pixel counter, start pulse aligned with sensor_clk.
    always_ff @(posedge clk_3M or posedge reset) begin
        if (reset) begin
            run_q       <= 1'b0;
            pixel_idx   <= '0;
            start_pulse <= 1'b0;
        end else begin
            run_q       <= enable;
            pixel_idx   <= pix_d;
            start_pulse <= enable && (pix_d == '0);
        end
    end

endmodule

// File: tb/tb_sensor_timing_gen.sv
// Directed bench for sensor_timing_gen (PIXELS=4): table-driven vectors plus
// hand-written sequences for ratio reload, abort and asynchronous reset.
module tb_sensor_timing_gen;

    logic       clk_3M;
    logic       reset;
    logic       enable;
    logic [7:0] div_in;
    logic       div_load;
    logic       sensor_clk, sensor_tick, start_pulse, frame_done, div_err;
    logic [7:0] pixel_idx;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit         en;
        bit         ld;
        logic [7:0] din;
        bit         e_clk;
        bit         e_tick;
        bit         e_start;
        int         e_pix;
        bit         e_fd;
        bit         e_err;
    } vec_t;

    vec_t tbl[24];

    sensor_timing_gen #(
        .CNT_W       (8),
        .DEFAULT_DIV (20),
        .PIXELS      (4),
        .PIX_W       (8)
    ) dut (
        .clk_3M      (clk_3M),
        .reset       (reset),
        .enable      (enable),
        .div_in      (div_in),
        .div_load    (div_load),
        .sensor_clk  (sensor_clk),
        .sensor_tick (sensor_tick),
        .start_pulse (start_pulse),
        .pixel_idx   (pixel_idx),
        .frame_done  (frame_done),
        .div_err     (div_err)
    );

    initial begin
        clk_3M = 1'b0;
        forever #5 clk_3M = ~clk_3M;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_clk, input int e_tick,
                             input int e_start, input int e_pix, input int e_fd,
                             input int e_err);
        chk({tag, " sensor_clk"},  int'(sensor_clk),  e_clk);
        chk({tag, " sensor_tick"}, int'(sensor_tick), e_tick);
        chk({tag, " start_pulse"}, int'(start_pulse), e_start);
        chk({tag, " pixel_idx"},   int'(pixel_idx),   e_pix);
        chk({tag, " frame_done"},  int'(frame_done),  e_fd);
        chk({tag, " div_err"},     int'(div_err),     e_err);
    endtask

    // Drive inputs for the next rising edge, then sample on the following falling edge.
    task automatic cyc(input bit en, input bit ld, input logic [7:0] din);
        enable   = en;
        div_load = ld;
        div_in   = din;
        @(posedge clk_3M);
        @(negedge clk_3M);
    endtask

    initial begin
        int k, d, p;
        bit tk;

        // PIXELS=4, D=5 frame: {en, ld, din, clk, tick, start, pix, fd, err}
        tbl[0]  = '{1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0};
        tbl[23] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};

        // Reset state
        reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_in = 8'd0;
        @(posedge clk_3M); @(posedge clk_3M); @(negedge clk_3M);
        check_all("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 8'd0);
        check_all("idle", 0, 0, 0, 0, 0, 0);

        // Default ratio 20: 10 high / 10 low, tick every 20, frame of 4 periods
        for (int c = 0; c < 80; c++) begin
            cyc(1, 0, 8'd0);
            k = c % 20; p = (c / 20) % 4; tk = (k == 19);
            check_all($sformatf("t1 c=%0d", c), int'(k < 10), int'(tk), int'(p == 0), p,
                      int'(tk && p == 3), 0);
        end
        cyc(0, 0, 8'd0);
        check_all("t1 stop", 0, 0, 0, 0, 0, 0);

        // Load 7 mid-period, then a rejected load of 1
        for (int c = 0; c < 63; c++) begin
            cyc(1, (c == 6) || (c == 49), (c == 6) ? 8'd7 : 8'd1);
            if (c < 20) begin k = c; d = 20; p = 0; end
            else begin k = (c - 20) % 7; d = 7; p = (1 + (c - 20) / 7) % 4; end
            tk = (k == d - 1);
            check_all($sformatf("t2 c=%0d", c), int'(k < d / 2), int'(tk), int'(p == 0), p,
                      int'(tk && p == 3), int'(c == 49));
        end
        cyc(0, 0, 8'd0);
        check_all("t2 stop", 0, 0, 0, 0, 0, 0);

        // Table: idle load of 5, rejected load of 0, one full D=5 frame
        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].en, tbl[i].ld, tbl[i].din);
            check_all($sformatf("t3 v=%0d", i), int'(tbl[i].e_clk), int'(tbl[i].e_tick),
                      int'(tbl[i].e_start), tbl[i].e_pix, int'(tbl[i].e_fd),
                      int'(tbl[i].e_err));
        end
        cyc(0, 1, 8'd20);
        check_all("t3 stop", 0, 0, 0, 0, 0, 0);

        // Load 4 on the tick, then 6 and 9 inside the 4-cycle period: last wins
        for (int c = 0; c < 43; c++) begin
            cyc(1, (c >= 20) && (c <= 22), (c == 20) ? 8'd4 : (c == 21) ? 8'd6 : 8'd9);
            if (c < 20)      begin k = c;      d = 20; p = 1 - 1; end
            else if (c < 24) begin k = c - 20; d = 4;  p = 1; end
            else if (c < 33) begin k = c - 24; d = 9;  p = 2; end
            else if (c < 42) begin k = c - 33; d = 9;  p = 3; end
            else             begin k = 0;      d = 9;  p = 0; end
            tk = (k == d - 1);
            check_all($sformatf("t4 c=%0d", c), int'(k < d / 2), int'(tk), int'(p == 0), p,
                      int'(tk && p == 3), 0);
        end
        cyc(0, 1, 8'd20);
        check_all("t4 stop", 0, 0, 0, 0, 0, 0);

        // Drop enable at cntr=12 of pixel 2, then re-enable
        for (int c = 0; c < 53; c++) begin
            cyc(1, 0, 8'd0);
            k = c % 20; p = c / 20;
            check_all($sformatf("t5 c=%0d", c), int'(k < 10), int'(k == 19), int'(p == 0), p, 0, 0);
        end
        cyc(0, 0, 8'd0);
        check_all("t5 abort", 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            cyc(1, 0, 8'd0);
            check_all($sformatf("t5 re c=%0d", c), int'(c < 10), 0, 1, 0, 0, 0);
        end

        // Asynchronous reset with a pending load of 6
        cyc(1, 1, 8'd6);
        check_all("t6 pre", 1, 0, 1, 0, 0, 0);
        #2 reset = 1'b1; div_load = 1'b0;
        #1 check_all("t6 async", 0, 0, 0, 0, 0, 0);
        @(posedge clk_3M); @(negedge clk_3M);
        check_all("t6 hold", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int c = 0; c < 21; c++) begin
            cyc(1, 0, 8'd0);
            k = c % 20; p = c / 20;
            check_all($sformatf("t6 c=%0d", c), int'(k < 10), int'(k == 19), int'(p == 0), p, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_timing_gen.md
Name: sensor_timing_gen

Overview:
Parametrised successor to the fixed divide-by-20 sensor clock divider.
- Divides clk_3M by a runtime-programmable ratio.
- Produces a registered near-50%-duty sensor_clk and a one-cycle terminal-count tick.
- Sequences pixel readout: a start pulse on pixel 0 of each frame and a frame_done strobe.
- Sits between the system clock domain and the optical sensor array's clock/start-integration pins.

Parameters:
CNT_W, 8, width of divide counter and divide-ratio register
DEFAULT_DIV, 20, divide ratio after reset (must be >= 2 and < 2**CNT_W)
PIXELS, 128, sensor periods per frame (>= 2)
PIX_W, 8, width of pixel_idx (2**PIX_W >= PIXELS)

Ports:
clk_3M  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run request; low holds block idle
div_in  in  CNT_W  new divide ratio
div_load  in  1  one-cycle strobe: request div_in as new ratio
sensor_clk  out  1  divided sensor clock, flop output
sensor_tick  out  1  one-cycle strobe on last clk_3M cycle of each sensor period
start_pulse  out  1  high for the whole first sensor period of each frame, flop output
pixel_idx  out  PIX_W  index of current sensor period within frame
frame_done  out  1  one-cycle strobe coinciding with sensor_tick of pixel PIXELS-1
div_err  out  1  one-cycle strobe: rejected div_load

Behaviour:
Interface:
- Clock is clk_3M. Reset is reset: asynchronous, active-high.

Reset:
- All outputs 0; pixel_idx 0.
- Internal state: cntr=0, div_q=DEFAULT_DIV, pending empty, run_q=0.
- Assertion mid-operation aborts immediately with no completion of the current period or frame.

Run control:
- run_q is enable registered.
- While run_q=0: cntr=0, pixel_idx=0, and all of sensor_clk, sensor_tick, start_pulse and frame_done are 0.
- Enable sampled high at edge k gives run_q=1 and cntr=0 from edge k, so the first period starts immediately.
- Enable sampled low mid-period aborts at the next edge. There is no partial tick. pixel_idx clears to 0.

Divider:
- While running, cntr counts 0..div_q-1 and wraps to 0.
- sensor_tick = run_q && cntr==div_q-1.
- sensor_clk equals (run_q && cntr < div_q>>1) in every cycle. It is implemented as a flop driven from next-state logic, so it is glitch-free.
- Duty: high floor(D/2) cycles, low ceil(D/2) cycles.

Ratio update:
- div_load with div_in < 2 is rejected: div_err=1 for the next cycle, and div_q and pending are unchanged.
- A valid div_load writes pending. A later load before the boundary overwrites pending (last wins).
- pending transfers to div_q only at a period boundary, i.e. the edge where cntr wraps, or on any edge while run_q=0. The period in progress always completes at the old length.
- div_load in the same cycle as sensor_tick: the new value governs the very next period.

Pixel sequencing:
- On each sensor_tick, pixel_idx increments, wrapping from PIXELS-1 to 0.
- start_pulse = run_q && pixel_idx==0, as a flop output aligned with sensor_clk.
- frame_done = sensor_tick && pixel_idx==PIXELS-1.

Arithmetic:
- All counters are unsigned.
- No state is reachable where cntr >= div_q, because a ratio change never takes effect mid-period.

Decomposition:
Package sensor_timing_pkg:
- DIV_MIN=2.
- Default CNT_W, DEFAULT_DIV, PIXELS, PIX_W values shared with the readout/ADC capture blocks.

Sub-module sensor_div_core:
- Holds cntr, div_q, the pending register, validation and div_err.
- Outputs sensor_clk and sensor_tick.

Top level:
- Adds run_q, the pixel counter, start_pulse and frame_done.

Test Plan:
1. Defaults, enable=1 held -> sensor_clk 10 high / 10 low; sensor_tick every 20 cycles; first rising sensor_clk in the cycle after enable sampled.
2. div_load=1 with div_in=7 mid-period -> current period finishes at 20 cycles; next periods are 3 high / 4 low, tick every 7. Then load div_in=1 -> div_err pulses one cycle; period stays 7.
3. PIXELS=4, D=5 -> start_pulse high for cycles 0-4 of each 20-cycle frame; pixel_idx sequence 0,1,2,3,0; frame_done on cycle 19.
4. div_load coincident with sensor_tick (D 20->4), then two loads (6, then 9) within one period -> next period 4; the period after is 9; 6 is never used.
5. enable dropped at cntr=12, pixel_idx=2 -> next cycle all outputs 0 and pixel_idx=0. Re-enable -> fresh frame with start_pulse at once.
6. reset asserted asynchronously mid-frame with a pending load -> outputs 0 immediately. After release, div_q=20 and the pending load is discarded.
